// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among host (port 0) and async ports 1-3.
// Latency: grant 1 cycle after request is sampled in IDLE; done/timeout pulses 1 cycle after the deciding BUSY cycle.
// Backpressure: requesters hold iREQ until their oDONE pulse; new requests wait until the arbiter returns to IDLE.
module sdram_port_arbiter #(
    parameter int GUARD_CYCLES = 2,
    parameter int TIMEOUT      = 255,
    parameter bit HOST_PRIO    = 1'b0
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [3:0] iREQ,
    input  logic       iSDR_Done,
    output logic [1:0] oSelect,
    output logic [3:0] oGNT,
    output logic [3:0] oDONE,
    output logic       oTimeout,
    output logic       oBusy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // Guard counter is loaded with GUARD_CYCLES-1 so GUARD lasts exactly GUARD_CYCLES cycles.
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);
    localparam bit         TIMEOUT_EN = (TIMEOUT != 0);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] done_q, done_d;
    logic       tout_q, tout_d;
    logic       busy_q, busy_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] gcnt_q, gcnt_d;

    logic [1:0] win;
    logic [1:0] cand;
    logic       found;
    logic       done_ok;

    // Winner search: first requesting port starting at the round-robin pointer; host override when enabled.
    always_comb begin
        win   = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && iREQ[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        if (HOST_PRIO && iREQ[0]) begin
            win = 2'd0;
        end
    end

    // Next-state and output logic; pulses default low so they last a single cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        tout_d  = 1'b0;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        // An async port's mux needs one cycle to launch, so a done seen in its first BUSY
        // cycle is stale; port 0 done passes straight through and is honoured at once.
        done_ok = iSDR_Done && !((tcnt_q == 8'd0) && (sel_q != 2'd0));
        case (state_q)
            ST_IDLE: begin
                if (iREQ != 4'b0000) begin
                    sel_d   = win;
                    gnt_d   = 4'b0001 << win;
                    busy_d  = 1'b1;
                    ptr_d   = win + 2'd1;
                    tcnt_d  = 8'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done_ok) begin
                    done_d  = gnt_q;
                    gcnt_d  = GUARD_LAST;
                    state_d = ST_GUARD;
                end else begin
                    // Saturate so a disabled watchdog never wraps back into the first-cycle window.
                    tcnt_d = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                    if (TIMEOUT_EN && (tcnt_q == TCNT_LAST)) begin
                        tout_d  = 1'b1;
                        done_d  = gnt_q;
                        gcnt_d  = GUARD_LAST;
                        state_d = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                // Select stays put so the mux FSM can finish its tail, then drops to 0 for an IDLE cycle.
                if (gcnt_q == 8'd0) begin
                    sel_d   = 2'd0;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any grant without issuing a done.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            done_q  <= 4'b0000;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd0;
            tcnt_q  <= 8'd0;
            gcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign oSelect  = sel_q;
    assign oGNT     = gnt_q;
    assign oDONE    = done_q;
    assign oTimeout = tout_q;
    assign oBusy    = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: two instances (round-robin with watchdog, host-priority without watchdog).
// Transaction-level model predicts grant/done/release events; monitors compare them as the DUTs produce them.
// Requesters hold requests until their done pulse; done input is randomised, including stuck-high phases.
module tb_sdram_port_arbiter;

    localparam int G0 = 2, T0 = 8, H0 = 0;
    localparam int G1 = 3, T1 = 0, H1 = 1;

    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int K_REL   = 2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  port;
        logic [31:0] cyc;
        logic        to;
    } ev_t;

    logic       clk;
    logic       rst_a  [2];
    logic [3:0] req_a  [2];
    logic       sdone_a[2];
    logic [1:0] sel_a  [2];
    logic [3:0] gnt_a  [2];
    logic [3:0] dne_a  [2];
    logic       to_a   [2];
    logic       bsy_a  [2];
    logic       mon_en [2];

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t q0[$];
    ev_t q1[$];

    sdram_port_arbiter #(.GUARD_CYCLES(G0), .TIMEOUT(T0), .HOST_PRIO(H0)) dut0 (
        .iCLK(clk), .iRST_n(rst_a[0]), .iREQ(req_a[0]), .iSDR_Done(sdone_a[0]),
        .oSelect(sel_a[0]), .oGNT(gnt_a[0]), .oDONE(dne_a[0]), .oTimeout(to_a[0]), .oBusy(bsy_a[0])
    );

    sdram_port_arbiter #(.GUARD_CYCLES(G1), .TIMEOUT(T1), .HOST_PRIO(H1)) dut1 (
        .iCLK(clk), .iRST_n(rst_a[1]), .iREQ(req_a[1]), .iSDR_Done(sdone_a[1]),
        .oSelect(sel_a[1]), .oGNT(gnt_a[1]), .oDONE(dne_a[1]), .oTimeout(to_a[1]), .oBusy(bsy_a[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int enc(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Arbitration rule: host override if enabled, else first requester from ptr going upward mod 4.
    function automatic int pick(input logic [3:0] r, input int ptr, input int hp);
        if (hp != 0 && r[0]) return 0;
        for (int i = 0; i < 4; i++) begin
            if (r[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return 0;
    endfunction

    function automatic void push_ev(input int id, input int kind, input int port, input int c, input logic t);
        ev_t e;
        e.kind = 2'(kind);
        e.port = 2'(port);
        e.cyc  = 32'(c);
        e.to   = t;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endfunction

    function automatic bit peek(input int id, output ev_t e);
        e = '0;
        if (id == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0[0];
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1[0];
        end
        return 1'b1;
    endfunction

    function automatic void pop_ev(input int id);
        if (id == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
    endfunction

    task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    task automatic check_idle(input int id, input string name);
        cmp(name, id, {19'd0, sel_a[id], gnt_a[id], dne_a[id], to_a[id], bsy_a[id]}, 32'd0);
    endtask

    task automatic observe(input int id, input int kind, input int port, input int n, input logic t);
        ev_t e;
        n_cmp++;
        if (!peek(id, e)) begin
            n_bad++;
            $display("FAIL dut%0d unexpected_event: got kind=%0d port=%0d cyc=%0d to=%0d, expected none",
                     id, kind, port, n, t);
        end else begin
            pop_ev(id);
            if (int'(e.kind) != kind || int'(e.port) != port || int'(e.cyc) != n || e.to != t) begin
                n_bad++;
                $display("FAIL dut%0d event: got kind=%0d port=%0d cyc=%0d to=%0d, expected kind=%0d port=%0d cyc=%0d to=%0d",
                         id, kind, port, n, t, e.kind, e.port, e.cyc, e.to);
            end
        end
    endtask

    // Monitor: per-cycle output invariants plus event matching against the predicted queue.
    task automatic monitor(input int id);
        logic [3:0] pg;
        ev_t        e;
        int         n;
        bit         inv_ok;
        pg = 4'b0;
        forever begin
            @(negedge clk);
            if (mon_en[id]) begin
                n = cyc;
                inv_ok = ((gnt_a[id] & (gnt_a[id] - 4'd1)) == 4'd0)
                      && (int'(sel_a[id]) == enc(gnt_a[id]))
                      && (bsy_a[id] == (gnt_a[id] != 4'd0))
                      && (dne_a[id] == 4'd0 || dne_a[id] == gnt_a[id])
                      && (!to_a[id] || dne_a[id] != 4'd0);
                n_cmp++;
                if (!inv_ok) begin
                    n_bad++;
                    $display("FAIL dut%0d invariant cyc=%0d: got gnt=%b sel=%0d done=%b to=%b busy=%b, expected consistent one-hot outputs",
                             id, n, gnt_a[id], sel_a[id], dne_a[id], to_a[id], bsy_a[id]);
                end
                while (peek(id, e) && int'(e.cyc) < n) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dut%0d missed_event: got nothing by cyc=%0d, expected kind=%0d port=%0d cyc=%0d",
                             id, n, e.kind, e.port, e.cyc);
                    pop_ev(id);
                end
                if (pg == 4'd0 && gnt_a[id] != 4'd0) observe(id, K_GRANT, enc(gnt_a[id]), n, 1'b0);
                if (pg != 4'd0 && gnt_a[id] == 4'd0) observe(id, K_REL, enc(pg), n, 1'b0);
                if (dne_a[id] != 4'd0)               observe(id, K_DONE, enc(dne_a[id]), n, to_a[id]);
            end
            pg = gnt_a[id];
        end
    endtask

    // Directed: reset values, then async reset in the middle of a port-1 grant.
    task automatic reset_test(input int id);
        req_a[id] = 4'b0; sdone_a[id] = 1'b0; rst_a[id] = 1'b0; mon_en[id] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle(id, "reset_state");
        @(posedge clk); #1 rst_a[id] = 1'b1;
        @(posedge clk); #1 req_a[id] = 4'b0010;
        @(negedge clk);
        check_idle(id, "no_grant_same_cycle");
        @(posedge clk); @(negedge clk);
        cmp("grant_latency", id, {26'd0, gnt_a[id], sel_a[id]}, {26'd0, 4'b0010, 2'd1});
        @(posedge clk); #2 rst_a[id] = 1'b0;
        #1 check_idle(id, "async_reset_mid_busy");
        req_a[id] = 4'b0;
        @(posedge clk); #1 rst_a[id] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle(id, "idle_after_reset");
        end
    endtask

    // Random traffic driven cycle by cycle; the model predicts each transaction's events.
    task automatic run_random(input int id, input int ncyc);
        int g, tmo, hp, n, ptr, s, w, free_at, clr_at, clr_port, mode;
        logic [3:0] pend, drv;
        logic       d;
        bit         busy, ended;
        g   = (id == 0) ? G0 : G1;
        tmo = (id == 0) ? T0 : T1;
        hp  = (id == 0) ? H0 : H1;
        pend = 4'b0; ptr = 0; busy = 1'b0; s = 0; w = 0; free_at = 0;
        clr_at = -1; clr_port = 0; mode = 0; ended = 1'b0;
        mon_en[id] = 1'b1;
        for (int t = 0; t < ncyc + 3000; t++) begin
            @(posedge clk); #1;
            n = cyc;
            if (n == clr_at) pend[clr_port] = 1'b0;
            if (t >= ncyc && !busy && pend == 4'b0 && n >= free_at) begin
                ended = 1'b1;
                break;
            end
            if (t % 40 == 0) mode = $urandom_range(0, 3);
            if (t < ncyc) begin
                for (int p = 0; p < 4; p++) if ($urandom_range(0, 5) == 0) pend[p] = 1'b1;
            end
            drv = pend;
            if (busy && $urandom_range(0, 3) == 0) drv[w] = 1'b0;
            case (mode)
                2:       d = ($urandom_range(0, 19) == 0);
                3:       d = 1'b1;
                default: d = ($urandom_range(0, 3) == 0);
            endcase
            req_a[id]   = drv;
            sdone_a[id] = d;
            if (busy) begin
                if (d && !(n == s && w != 0)) begin
                    push_ev(id, K_DONE, w, n + 1, 1'b0);
                    push_ev(id, K_REL, w, n + 1 + g, 1'b0);
                    busy = 1'b0; free_at = n + 1 + g; clr_at = n + 1; clr_port = w;
                end else if (tmo != 0 && n - s == tmo - 1) begin
                    push_ev(id, K_DONE, w, n + 1, 1'b1);
                    push_ev(id, K_REL, w, n + 1 + g, 1'b0);
                    busy = 1'b0; free_at = n + 1 + g; clr_at = n + 1; clr_port = w;
                end
            end else if (n >= free_at && pend != 4'b0) begin
                w = pick(pend, ptr, hp);
                ptr = (w + 1) % 4;
                busy = 1'b1;
                s = n + 1;
                push_ev(id, K_GRANT, w, n + 1, 1'b0);
            end
        end
        req_a[id] = 4'b0;
        sdone_a[id] = 1'b0;
        if (!ended) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d drain_budget: got traffic still pending, expected drain within budget", id);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_a[i] = 1'b0; req_a[i] = 4'b0; sdone_a[i] = 1'b0; mon_en[i] = 1'b0;
        end
        fork
            monitor(0);
            monitor(1);
        join_none
        fork
            begin reset_test(0); run_random(0, 3000); end
            begin reset_test(1); run_random(1, 3000); end
        join
        repeat (10) @(negedge clk);
        cmp("queue_drained", 0, 32'(q0.size()), 32'd0);
        cmp("queue_drained", 1, 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "time limit expired");
    end

endmodule
